// File: rtl/exec_ififo.sv
// Always-on work-item FIFO with power-gated issue: first-word fall-through, zero-cycle read latency.
// in_ready drops only when full; out_valid is masked while the execution unit is isolated, off, or waking.
module exec_ififo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int WAKE_HOLD = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ififo_rdy,
  input  logic              iso_enable,
  input  logic              pwr_down,
  input  logic              pwron_reset,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  occ_hwm,
  output logic [7:0]        wake_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [3:0] HOLD_INIT = 4'(WAKE_HOLD);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  occ_hwm_q, occ_hwm_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [7:0]        wake_cnt_q, wake_cnt_d;
  logic              pwron_reset_q, pwron_reset_d;
  logic              exec_live;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != FULL);
  assign ififo_rdy = (count_q != '0);
  assign exec_live = !iso_enable && !pwr_down && !pwron_reset && (hold_cnt_q == 4'd0);
  assign out_valid = ififo_rdy && exec_live;
  assign out_data  = ififo_rdy ? mem_q[rd_ptr_q] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign occ_hwm   = occ_hwm_q;
  assign wake_cnt  = wake_cnt_q;

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    occ_hwm_d     = (count_d > occ_hwm_q) ? count_d : occ_hwm_q;
    // Hold-off restarts on every pwron_reset cycle, so it counts from the last one.
    hold_cnt_d    = hold_cnt_q;
    if (pwron_reset) hold_cnt_d = HOLD_INIT;
    else if (hold_cnt_q != 4'd0) hold_cnt_d = hold_cnt_q - 4'd1;
    pwron_reset_d = pwron_reset;
    wake_cnt_d    = wake_cnt_q;
    if (pwron_reset_q && !pwron_reset && (wake_cnt_q != 8'hFF)) wake_cnt_d = wake_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      occ_hwm_q     <= '0;
      hold_cnt_q    <= 4'd0;
      wake_cnt_q    <= 8'd0;
      pwron_reset_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      occ_hwm_q     <= occ_hwm_d;
      hold_cnt_q    <= hold_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      pwron_reset_q <= pwron_reset_d;
    end
  end

  // Storage is not reset; a write racing rst is harmless because the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/exec_ififo.md
Name: exec_ififo

Overview:
- Input FIFO in the always-on domain, upstream of the execution unit and beside the power management unit.
- Buffers work items from the upstream producer and drives ififo_rdy (non-empty) to the PMU.
- Blocks issue to the execution unit while it is isolated, powered down, in power-on reset, or in a short wake hold-off window.
- Keeps contents across execution-unit power cycles.

Parameters:
DATA_W, 32, width of each work item
DEPTH, 8, number of FIFO entries; power of two, >= 2
WAKE_HOLD, 2, cycles after pwron_reset deasserts before issue resumes; 0..15
CNT_W, $clog2(DEPTH)+1, width of occupancy outputs (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream item valid
in_data  input  DATA_W  upstream item
in_ready  output  1  FIFO can accept
out_valid  output  1  item available to execution unit
out_data  output  DATA_W  head item
out_ready  input  1  execution unit accepts
ififo_rdy  output  1  FIFO non-empty, to PMU
iso_enable  input  1  from PMU
pwr_down  input  1  from PMU
pwron_reset  input  1  from PMU
count  output  CNT_W  current occupancy
occ_hwm  output  CNT_W  occupancy high-water mark
wake_cnt  output  8  number of completed wake events, saturating

Behaviour:
- Storage: DEPTH x DATA_W array.
- Pointers: wr_ptr and rd_ptr, log2(DEPTH) bits, wrap naturally modulo DEPTH. count register is CNT_W bits.
- Push: in_valid && in_ready. Write in_data at wr_ptr, then wr_ptr+1.
  - in_ready = (count != DEPTH). Independent of power state.
- ififo_rdy = (count != 0), combinational from the registered count.
  - Push at edge N gives ififo_rdy = 1 in the cycle after edge N.
- exec_live = !iso_enable && !pwr_down && !pwron_reset && (hold_cnt == 0).
- out_valid = (count != 0) && exec_live.
- Pop: out_valid && out_ready, then rd_ptr+1.
- out_data = mem[rd_ptr] when count != 0, else 0. First-word fall-through; zero-cycle read latency.
- out_valid may drop without a handshake when exec_live falls. The execution unit is isolated at that point, so this is the one permitted exception to the valid-hold rule.
- Head data never changes while count != 0 and no pop occurs.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- No bypass: an item pushed into an empty FIFO is visible on out_valid the next cycle at earliest.
- Full: in_ready = 0, in_valid ignored, nothing is overwritten.
- Empty: out_valid = 0, out_ready ignored.
- Wake hold counter hold_cnt, 4 bits:
  - Any cycle with pwron_reset = 1: load WAKE_HOLD.
  - Else if hold_cnt != 0: decrement.
  - Result: issue is blocked for exactly WAKE_HOLD cycles after the last pwron_reset = 1 cycle. With WAKE_HOLD = 0, issue resumes the cycle after pwron_reset falls, given other gates clear.
- wake_cnt: increments by 1 on the falling edge of pwron_reset (registered previous value = 1, current = 0). Saturates at 255.
- occ_hwm: registered. Updated to the next count whenever the next count > occ_hwm. Never decreases except on rst.
- Reset values:
  - wr_ptr, rd_ptr, count, hold_cnt, wake_cnt, occ_hwm, pwron_reset history bit = 0.
  - Outputs: in_ready = 1, out_valid = 0, ififo_rdy = 0, out_data = 0, count = 0, occ_hwm = 0, wake_cnt = 0.
  - Memory contents are not reset.
- rst mid-operation: all queued items are discarded; the FIFO is empty the cycle after rst is sampled. A push or pop coincident with rst is lost.
- Power inputs may change in any cycle, in any combination. Gating is purely combinational on the current inputs plus hold_cnt.

Test Plan:
1. Reset, power gates 0, out_ready = 0; push A, B, C on consecutive cycles.
   -> ififo_rdy = 1 the cycle after A's push; count = 3; out_valid = 1 with out_data = A; occ_hwm = 3.
2. DEPTH = 8, out_ready = 0, in_valid held high for 9 cycles.
   -> in_ready = 0 after the 8th push; count = 8; 9th item not stored; occ_hwm = 8.
3. count = 2, iso_enable = 1, out_ready = 1 for 5 cycles.
   -> out_valid = 0 throughout; count stays 2; ififo_rdy = 1. Drop iso_enable -> first pop returns the original head.
4. count = 1, WAKE_HOLD = 2, pwron_reset high for 2 cycles then low, out_ready = 1.
   -> out_valid = 0 for 2 cycles after pwron_reset falls, 1 on the 3rd; item popped; wake_cnt = 1.
5. count = 4, simultaneous push X and pop for 3 cycles.
   -> count stays 4; popped items are the original head order; X items follow in order.
6. count = 5, rst high for 1 cycle.
   -> next cycle count = 0, ififo_rdy = 0, in_ready = 1, out_valid = 0, occ_hwm = 0, wake_cnt = 0.
